// File: rtl/imem_program_loader_pkg.sv
// Shared MIPS ISA constants and loader state encoding.
// Used by the instruction encoder and the program loader.
package imem_program_loader_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [2:0] OPSEL_RTYPE = 3'd0;
    localparam logic [2:0] OPSEL_BEQ   = 3'd1;
    localparam logic [2:0] OPSEL_SW    = 3'd2;
    localparam logic [2:0] OPSEL_LW    = 3'd3;
    localparam logic [2:0] OPSEL_ADDI  = 3'd4;
    localparam logic [2:0] OPSEL_J     = 3'd5;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/imem_program_loader_instr_encode.sv
// Combinational MIPS instruction assembler: op select plus fields -> 32-bit word.
// Op selects 6 and 7 produce a zero word and raise illegal_o.
module instr_encode
    import imem_program_loader_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OPSEL_RTYPE: word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            OPSEL_BEQ:   word_o = {OPC_BEQ,  rs_i, rt_i, imm_i};
            OPSEL_SW:    word_o = {OPC_SW,   rs_i, rt_i, imm_i};
            OPSEL_LW:    word_o = {OPC_LW,   rs_i, rt_i, imm_i};
            OPSEL_ADDI:  word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
            OPSEL_J:     word_o = {OPC_J, target_i};
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Streams encoded instructions into instruction memory, one registered write per accepted request.
// A single pending-write register gives one-cycle latency while still accepting every cycle.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0] ONE_C     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_FILL = {1'b0, {ADDR_W{1'b1}}};

    loader_state_e     state_q, state_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic [ADDR_W:0]   fill;
    logic              accept;

    instr_encode u_encode (
        .op_i      (in_op),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .funct_i   (in_funct),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Words committed plus the one still on the write port.
    assign fill     = count_q + (pend_q ? ONE_C : '0);
    assign in_ready = (state_q == ST_LOAD) && (fill < DEPTH_C);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        err_d   = err_q;
        count_d = pend_q ? (count_q + ONE_C) : count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = ST_LOAD;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        if (enc_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            pend_d  = 1'b1;
                            addr_d  = BASE_ADDR + fill[ADDR_W-1:0];
                            wdata_d = enc_word;
                        end
                        if (in_last || (!enc_illegal && fill == LAST_FILL)) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A restart cancels the write sitting on the port this cycle.
    assign imem_we     = pend_q && !start;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign done        = (state_q == ST_DONE);
    assign err_illegal = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: a 64-word instance for the main
// scenarios and a 4-word instance (BASE_ADDR=3) for wrap and full behaviour.
module tb_imem_program_loader;
    import imem_program_loader_pkg::*;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, valid_a, valid_b, last;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    logic        ready_a, we_a, busy_a, done_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [6:0]  count_a;
    logic        ready_b, we_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int checks = 0;
    int errors = 0;

    wr_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];

    imem_program_loader #(.ADDR_W(6), .BASE_ADDR(6'd0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(valid_a), .in_ready(ready_a),
        .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_funct(funct), .in_imm(imm),
        .in_target(target), .in_last(last), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .count(count_a), .busy(busy_a), .done(done_a),
        .err_illegal(err_a)
    );

    imem_program_loader #(.ADDR_W(2), .BASE_ADDR(2'd3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(valid_b), .in_ready(ready_b),
        .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_funct(funct), .in_imm(imm),
        .in_target(target), .in_last(last), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .count(count_b), .busy(busy_b), .done(done_b),
        .err_illegal(err_b)
    );

    always @(negedge clk) begin
        if (we_a) obs_a.push_back({addr_a, wdata_a});
        if (we_b) obs_b.push_back({4'b0000, addr_b, wdata_b});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                           input logic [25:0] tg, input logic l);
        op = o; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg; last = l;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        tick(); tick();
        start = 1'b0;
        #1;
        checks++;
        if ({ready_a, we_a, busy_a, done_a, err_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 00000", {ready_a, we_a, busy_a, done_a, err_a});
        end
        checks++;
        if ({count_a, addr_a, wdata_a} !== '0) begin
            errors++;
            $display("FAIL reset_data got count=%0d addr=%0d wdata=%h expected 0", count_a, addr_a, wdata_a);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (ready_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got ready=%b busy=%b expected 0 0", ready_a, busy_a);
        end
        pulse_start();
        checks++;
        if (ready_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL start_ready got ready=%b busy=%b expected 1 1", ready_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e, o;
        valid_a = 1'b1;
        set_req(OPSEL_RTYPE, 5'd1, 5'd2, 5'd3, FUNCT_ADD, 16'd0, 26'd0, 1'b0);
        exp_a.push_back({6'd0, 32'h00221820});
        tick();
        checks++;
        if (we_a !== 1'b1 || addr_a !== 6'd0) begin
            errors++;
            $display("FAIL b2b_latency got we=%b addr=%0d expected 1 0", we_a, addr_a);
        end
        set_req(OPSEL_LW, 5'd0, 5'd4, 5'd0, 6'd0, 16'd8, 26'd0, 1'b0);
        exp_a.push_back({6'd1, 32'h8C040008});
        tick();
        set_req(OPSEL_J, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
        exp_a.push_back({6'd2, 32'h08000010});
        tick();
        valid_a = 1'b0; last = 1'b0;
        checks++;
        if (ready_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_flush got ready=%b busy=%b expected 0 1", ready_a, busy_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b1 || count_a !== 7'd3) begin
            errors++;
            $display("FAIL b2b_done got done=%b count=%0d expected 1 3", done_a, count_a);
        end
        tick();
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                errors++;
                $display("FAIL b2b_write got none expected addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_write got addr=%0d data=%h expected addr=%0d data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_encodings();
        wr_t e, o;
        obs_a.delete();
        pulse_start();
        valid_a = 1'b1;
        set_req(OPSEL_ADDI, 5'd5, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        exp_a.push_back({6'd0, 32'h20A5FFFF});
        tick();
        set_req(OPSEL_BEQ, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b0);
        exp_a.push_back({6'd1, 32'h1022FFFE});
        tick();
        set_req(OPSEL_SW, 5'd29, 5'd31, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1);
        exp_a.push_back({6'd2, 32'hAFBF0004});
        tick();
        valid_a = 1'b0; last = 1'b0;
        tick(); tick();
        checks++;
        if (done_a !== 1'b1 || count_a !== 7'd3) begin
            errors++;
            $display("FAIL enc_done got done=%b count=%0d expected 1 3", done_a, count_a);
        end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                errors++;
                $display("FAIL enc_write got none expected addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL enc_write got addr=%0d data=%h expected addr=%0d data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_illegal();
        wr_t e, o;
        obs_a.delete();
        pulse_start();
        valid_a = 1'b1;
        set_req(OPSEL_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
        exp_a.push_back({6'd0, 32'h20220001});
        tick();
        set_req(3'd7, 5'd9, 5'd9, 5'd9, 6'd9, 16'h1234, 26'h3FF, 1'b0);
        tick();
        checks++;
        if (we_a !== 1'b0 || err_a !== 1'b1) begin
            errors++;
            $display("FAIL illegal_nowrite got we=%b err=%b expected 0 1", we_a, err_a);
        end
        set_req(OPSEL_RTYPE, 5'd1, 5'd2, 5'd3, FUNCT_ADD, 16'd0, 26'd0, 1'b1);
        exp_a.push_back({6'd1, 32'h00221820});
        tick();
        valid_a = 1'b0; last = 1'b0;
        tick(); tick();
        checks++;
        if (done_a !== 1'b1 || count_a !== 7'd2 || err_a !== 1'b1) begin
            errors++;
            $display("FAIL illegal_done got done=%b count=%0d err=%b expected 1 2 1", done_a, count_a, err_a);
        end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                errors++;
                $display("FAIL illegal_write got none expected addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL illegal_write got addr=%0d data=%h expected addr=%0d data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        pulse_start();
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear got err=%b expected 0", err_a);
        end
    endtask

    task automatic test_full_wrap();
        wr_t e, o;
        obs_b.delete();
        pulse_start();
        valid_b = 1'b1;
        checks++;
        if (ready_b !== 1'b1) begin
            errors++;
            $display("FAIL full_ready0 got %b expected 1", ready_b);
        end
        for (int k = 1; k <= 5; k++) begin
            set_req(OPSEL_ADDI, 5'd0, 5'd1, 5'd0, 6'd0, 16'(k), 26'd0, 1'b0);
            if (k <= 4) exp_b.push_back({4'b0000, 2'(k + 2), 32'h20010000 | 32'(k)});
            tick();
            if (k == 4) begin
                checks++;
                if (ready_b !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready_drop got %b expected 0", ready_b);
                end
            end
        end
        valid_b = 1'b0;
        checks++;
        if (done_b !== 1'b1 || count_b !== 3'd4) begin
            errors++;
            $display("FAIL full_done got done=%b count=%0d expected 1 4", done_b, count_b);
        end
        tick(); tick();
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            checks++;
            if (obs_b.size() == 0) begin
                errors++;
                $display("FAIL full_write got none expected addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL full_write got addr=%0d data=%h expected addr=%0d data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_b.size() != 0) begin
            errors++;
            $display("FAIL full_extra got %0d extra writes expected 0", obs_b.size());
        end
    endtask

    task automatic test_start_abort();
        wr_t e, o;
        obs_a.delete();
        pulse_start();
        valid_a = 1'b1;
        set_req(OPSEL_ADDI, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0055, 26'd0, 1'b0);
        tick();
        valid_a = 1'b0;
        start = 1'b1;
        #1;
        checks++;
        if (we_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_we got %b expected 0", we_a);
        end
        tick();
        start = 1'b0;
        checks++;
        if (count_a !== 7'd0 || we_a !== 1'b0 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got count=%0d we=%b ready=%b expected 0 0 1", count_a, we_a, ready_a);
        end
        valid_a = 1'b1;
        set_req(OPSEL_LW, 5'd0, 5'd4, 5'd0, 6'd0, 16'd8, 26'd0, 1'b1);
        exp_a.push_back({6'd0, 32'h8C040008});
        tick();
        valid_a = 1'b0; last = 1'b0;
        tick(); tick();
        checks++;
        if (done_a !== 1'b1 || count_a !== 7'd1) begin
            errors++;
            $display("FAIL abort_done got done=%b count=%0d expected 1 1", done_a, count_a);
        end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                errors++;
                $display("FAIL abort_write got none expected addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_write got addr=%0d data=%h expected addr=%0d data=%h", o.addr, o.data, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_a.size() != 0) begin
            errors++;
            $display("FAIL abort_extra got %0d extra writes expected 0", obs_a.size());
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        valid_a = 1'b1;
        set_req(OPSEL_BEQ, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        valid_a = 1'b0;
        checks++;
        if ({ready_a, we_a, busy_a, done_a, err_a} !== 5'b0 || {count_a, addr_a, wdata_a} !== '0) begin
            errors++;
            $display("FAIL midreset got ctrl=%b count=%0d addr=%0d wdata=%h expected all 0",
                     {ready_a, we_a, busy_a, done_a, err_a}, count_a, addr_a, wdata_a);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got busy=%b ready=%b expected 0 0", busy_a, ready_a);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_encodings();
        test_illegal();
        test_full_wrap();
        test_start_abort();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
